// File: rtl/matriz_bank_if.sv
// Bus bundle for matriz_bank: addressed write, registered read, clear and scan
// control, plus the status/stream outputs.
interface matriz_bank_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int WIDTH = 32
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic             wr_en;
    logic [RW-1:0]    wr_row;
    logic [CW-1:0]    wr_col;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [RW-1:0]    rd_row;
    logic [CW-1:0]    rd_col;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             clr_req;
    logic             clr_done;
    logic             scan_start;
    logic [WIDTH-1:0] scan_data;
    logic             scan_valid;
    logic             scan_last;
    logic             busy;
    logic             err;

    modport master (
        output wr_en, wr_row, wr_col, wr_data,
        output rd_en, rd_row, rd_col,
        output clr_req, scan_start,
        input  rd_data, rd_valid, clr_done,
        input  scan_data, scan_valid, scan_last, busy, err
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_data,
        input  rd_en, rd_row, rd_col,
        input  clr_req, scan_start,
        output rd_data, rd_valid, clr_done,
        output scan_data, scan_valid, scan_last, busy, err
    );
endinterface

// File: rtl/matriz_bank.sv
// ROWS x COLS register grid with two preset cells, addressed write, 1-cycle read,
// row-by-row restore-to-reset clear and a row-major streaming scan.
module matriz_bank #(
    parameter int               ROWS   = 8,
    parameter int               COLS   = 8,
    parameter int               WIDTH  = 32,
    parameter int               P0_ROW = 1,
    parameter int               P0_COL = 2,
    parameter logic [WIDTH-1:0] P0_VAL = 'h123,
    parameter int               P1_ROW = 3,
    parameter int               P1_COL = 4,
    parameter logic [WIDTH-1:0] P1_VAL = 'h456
) (
    input  logic         clk,
    input  logic         reset,
    matriz_bank_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;

    state_t           state_reg;
    logic [RW-1:0]    clr_row_reg;
    logic [RW-1:0]    scan_row_reg, scan_row_next;
    logic [CW-1:0]    scan_col_reg, scan_col_next;
    logic             scan_end;
    logic             busy_reg, clr_done_reg, err_reg, err_next;
    logic             scan_valid_reg, scan_last_reg;
    logic [WIDTH-1:0] scan_data_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             rd_valid_reg;
    logic             idle, wr_ok, rd_ok, wr_fire;
    logic [ROWS-1:0]  clr_hit, wr_row_hit;
    logic [COLS-1:0]  wr_col_hit;
    logic [WIDTH-1:0] cell_q [ROWS][COLS];

    assign idle  = (state_reg == IDLE);
    assign wr_ok = (int'(bus.wr_row) < ROWS) && (int'(bus.wr_col) < COLS);
    assign rd_ok = (int'(bus.rd_row) < ROWS) && (int'(bus.rd_col) < COLS);
    // Only an uncontested, in-range write issued in IDLE reaches the array.
    assign wr_fire = idle && bus.wr_en && !bus.clr_req && !bus.scan_start && wr_ok;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign clr_hit[gi]    = (state_reg == CLEAR) && (clr_row_reg == RW'(gi));
        assign wr_row_hit[gi] = (bus.wr_row == RW'(gi));

        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            localparam logic [WIDTH-1:0] RST_VAL =
                (gi == P0_ROW && gj == P0_COL) ? P0_VAL :
                (gi == P1_ROW && gj == P1_COL) ? P1_VAL : '0;

            logic [WIDTH-1:0] q_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    q_reg <= RST_VAL;
                else if (clr_hit[gi])
                    q_reg <= RST_VAL;
                else if (wr_fire && wr_row_hit[gi] && wr_col_hit[gj])
                    q_reg <= bus.wr_data;
            end

            assign cell_q[gi][gj] = q_reg;
        end
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_colsel
        assign wr_col_hit[gi] = (bus.wr_col == CW'(gi));
    end

    // Next scan coordinate; (0,0) whenever a scan is about to start or end.
    assign scan_end = (scan_row_reg == RW'(ROWS - 1)) && (scan_col_reg == CW'(COLS - 1));

    always_comb begin
        scan_row_next = '0;
        scan_col_next = '0;
        if (state_reg == SCAN && !scan_end) begin
            if (scan_col_reg == CW'(COLS - 1)) begin
                scan_row_next = scan_row_reg + 1'b1;
            end else begin
                scan_row_next = scan_row_reg;
                scan_col_next = scan_col_reg + 1'b1;
            end
        end
    end

    always_comb begin
        err_next = 1'b0;
        if (!idle)
            err_next = bus.wr_en | bus.clr_req | bus.scan_start;
        else if (bus.clr_req)
            err_next = bus.scan_start | bus.wr_en;
        else if (bus.scan_start)
            err_next = bus.wr_en;
        else if (bus.wr_en)
            err_next = !wr_ok;
        if (bus.rd_en && !rd_ok)
            err_next = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            clr_row_reg    <= '0;
            scan_row_reg   <= '0;
            scan_col_reg   <= '0;
            busy_reg       <= 1'b0;
            clr_done_reg   <= 1'b0;
            scan_valid_reg <= 1'b0;
            scan_last_reg  <= 1'b0;
            scan_data_reg  <= '0;
            err_reg        <= 1'b0;
        end else begin
            err_reg <= err_next;
            case (state_reg)
                IDLE: begin
                    if (bus.clr_req) begin
                        state_reg   <= CLEAR;
                        clr_row_reg <= '0;
                        busy_reg    <= 1'b1;
                    end else if (bus.scan_start) begin
                        state_reg      <= SCAN;
                        scan_row_reg   <= '0;
                        scan_col_reg   <= '0;
                        busy_reg       <= 1'b1;
                        scan_valid_reg <= 1'b1;
                        scan_last_reg  <= 1'b0;
                        scan_data_reg  <= cell_q[scan_row_next][scan_col_next];
                    end
                end
                CLEAR: begin
                    if (clr_row_reg == RW'(ROWS - 1)) begin
                        state_reg    <= IDLE;
                        busy_reg     <= 1'b0;
                        clr_done_reg <= 1'b0;
                    end else begin
                        clr_row_reg  <= clr_row_reg + 1'b1;
                        clr_done_reg <= ((clr_row_reg + 1'b1) == RW'(ROWS - 1));
                    end
                end
                SCAN: begin
                    if (scan_end) begin
                        state_reg      <= IDLE;
                        busy_reg       <= 1'b0;
                        scan_valid_reg <= 1'b0;
                        scan_last_reg  <= 1'b0;
                        scan_data_reg  <= '0;
                    end else begin
                        scan_row_reg  <= scan_row_next;
                        scan_col_reg  <= scan_col_next;
                        scan_data_reg <= cell_q[scan_row_next][scan_col_next];
                        scan_last_reg <= (scan_row_next == RW'(ROWS - 1)) &&
                                         (scan_col_next == CW'(COLS - 1));
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Reads are served in every state; a same-edge write or clear lands after the sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en)
                rd_data_reg <= rd_ok ? cell_q[bus.rd_row][bus.rd_col] : '0;
        end
    end

    assign bus.rd_data    = rd_data_reg;
    assign bus.rd_valid   = rd_valid_reg;
    assign bus.clr_done   = clr_done_reg;
    assign bus.scan_data  = scan_data_reg;
    assign bus.scan_valid = scan_valid_reg;
    assign bus.scan_last  = scan_last_reg;
    assign bus.busy       = busy_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_matriz_bank.sv
// Directed bench for matriz_bank: an 8x8x32 instance and a 5x3 instance for
// out-of-range addressing; expected values are hand-derived constants.
module tb_matriz_bank;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    matriz_bank_if #(.ROWS(8), .COLS(8), .WIDTH(32)) i8 ();
    matriz_bank_if #(.ROWS(5), .COLS(3), .WIDTH(32)) i5 ();

    matriz_bank #(.ROWS(8), .COLS(8), .WIDTH(32)) u8 (
        .clk(clk), .reset(reset), .bus(i8)
    );
    matriz_bank #(.ROWS(5), .COLS(3), .WIDTH(32),
                  .P0_ROW(1), .P0_COL(2), .P0_VAL('h123),
                  .P1_ROW(3), .P1_COL(1), .P1_VAL('h456)) u5 (
        .clk(clk), .reset(reset), .bus(i5)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr8(input int r, input int c, input logic [31:0] d);
        i8.wr_en = 1'b1; i8.wr_row = 3'(r); i8.wr_col = 3'(c); i8.wr_data = d;
        @(negedge clk);
        i8.wr_en = 1'b0;
    endtask

    task automatic rd8(input int r, input int c);
        i8.rd_en = 1'b1; i8.rd_row = 3'(r); i8.rd_col = 3'(c);
        @(negedge clk);
        i8.rd_en = 1'b0;
    endtask

    task automatic wait_idle8(input string tag);
        int n = 0;
        while (i8.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, i8.busy, 0);
    endtask

    // Full 64-beat scan of the 8x8 bank expecting only the two presets.
    task automatic scan8(input string tag);
        logic [31:0] exp;
        i8.scan_start = 1'b1;
        @(negedge clk);
        i8.scan_start = 1'b0;
        for (int b = 0; b < 64; b++) begin
            exp = (b == 10) ? 32'h123 : (b == 28) ? 32'h456 : 32'h0;
            check({tag, ".valid"}, i8.scan_valid, 1);
            check({tag, ".data"}, i8.scan_data, exp);
            check({tag, ".last"}, i8.scan_last, (b == 63));
            check({tag, ".busy"}, i8.busy, 1);
            @(negedge clk);
        end
        check({tag, ".busy_end"}, i8.busy, 0);
        check({tag, ".valid_end"}, i8.scan_valid, 0);
        $display("[TB] %s: 64-beat scan done", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        {i8.wr_en, i8.rd_en, i8.clr_req, i8.scan_start} = '0;
        {i8.wr_row, i8.wr_col, i8.rd_row, i8.rd_col, i8.wr_data} = '0;
        {i5.wr_en, i5.rd_en, i5.clr_req, i5.scan_start} = '0;
        {i5.wr_row, i5.wr_col, i5.rd_row, i5.rd_col, i5.wr_data} = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.busy", i8.busy, 0);
        check("rst.rd_valid", i8.rd_valid, 0);
        check("rst.err", i8.err, 0);
        check("rst.scan_valid", i8.scan_valid, 0);
        check("rst.clr_done", i8.clr_done, 0);
        reset = 1'b1;
        @(negedge clk);
        $display("[TB] reset released");

        scan8("scan_rst");

        // Write then read, and same-cycle read/write
        wr8(7, 7, 32'hDEAD);
        rd8(7, 7);
        check("rd77.valid", i8.rd_valid, 1);
        check("rd77.data", i8.rd_data, 'hDEAD);
        $display("[TB] write/read (7,7)");
        i8.wr_en = 1'b1; i8.wr_row = 3'd0; i8.wr_col = 3'd0; i8.wr_data = 32'h1;
        i8.rd_en = 1'b1; i8.rd_row = 3'd0; i8.rd_col = 3'd0;
        @(negedge clk);
        i8.wr_en = 1'b0; i8.rd_en = 1'b0;
        check("rw00.old", i8.rd_data, 0);
        check("rw00.err", i8.err, 0);
        rd8(0, 0);
        check("rd00.new", i8.rd_data, 1);
        @(negedge clk);
        check("rd00.valid_drop", i8.rd_valid, 0);
        check("rd00.hold", i8.rd_data, 1);
        $display("[TB] same-cycle read/write (0,0)");

        // Fill with FF, clear, read the row being cleared mid-sequence
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                wr8(r, c, 32'hFF);
        i8.clr_req = 1'b1;
        @(negedge clk);
        i8.clr_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("clr.busy", i8.busy, 1);
            check("clr.done", i8.clr_done, (c == 7));
            if (c == 3) begin
                check("clr.rd_valid", i8.rd_valid, 1);
                check("clr.rd_old", i8.rd_data, 'hFF);
            end
            i8.rd_en = (c == 2); i8.rd_row = 3'd2; i8.rd_col = 3'd0;
            @(negedge clk);
        end
        i8.rd_en = 1'b0;
        check("clr.busy_end", i8.busy, 0);
        check("clr.done_end", i8.clr_done, 0);
        $display("[TB] clear sequence");
        scan8("scan_clr");

        // Write during scan is rejected
        i8.scan_start = 1'b1;
        @(negedge clk);
        i8.scan_start = 1'b0;
        repeat (4) @(negedge clk);
        i8.wr_en = 1'b1; i8.wr_row = 3'd1; i8.wr_col = 3'd2; i8.wr_data = 32'hBEEF;
        @(negedge clk);
        i8.wr_en = 1'b0;
        check("scanwr.err", i8.err, 1);
        check("scanwr.valid", i8.scan_valid, 1);
        @(negedge clk);
        check("scanwr.err_pulse", i8.err, 0);
        wait_idle8("scanwr.idle");
        rd8(1, 2);
        check("scanwr.cell", i8.rd_data, 'h123);
        $display("[TB] write during scan rejected");

        // clr_req + scan_start together, then clr_req while busy
        i8.clr_req = 1'b1; i8.scan_start = 1'b1;
        @(negedge clk);
        i8.scan_start = 1'b0;
        check("prio.err", i8.err, 1);
        check("prio.busy", i8.busy, 1);
        check("prio.scan_valid", i8.scan_valid, 0);
        @(negedge clk);
        i8.clr_req = 1'b0;
        check("busyclr.err", i8.err, 1);
        seen = 0;
        for (int n = 0; n < 20 && i8.busy; n++) begin
            if (i8.clr_done) seen++;
            @(negedge clk);
        end
        check("prio.clr_done_once", seen, 1);
        check("prio.idle", i8.busy, 0);
        $display("[TB] priority and busy rejection");

        // 5x3 instance: out-of-range write and read
        i5.wr_en = 1'b1; i5.wr_row = 3'd6; i5.wr_col = 2'd0; i5.wr_data = 32'hAA;
        @(negedge clk);
        i5.wr_en = 1'b0;
        check("np2.wr_err", i5.err, 1);
        i5.rd_en = 1'b1; i5.rd_row = 3'd1; i5.rd_col = 2'd2;
        @(negedge clk);
        check("np2.rd_ok", i5.rd_data, 'h123);
        check("np2.rd_ok_err", i5.err, 0);
        i5.rd_row = 3'd0; i5.rd_col = 2'd3;
        @(negedge clk);
        i5.rd_en = 1'b0;
        check("np2.rd_oor_data", i5.rd_data, 0);
        check("np2.rd_oor_valid", i5.rd_valid, 1);
        check("np2.rd_oor_err", i5.err, 1);
        i5.scan_start = 1'b1;
        @(negedge clk);
        i5.scan_start = 1'b0;
        for (int b = 0; b < 15; b++) begin
            check("np2.scan_valid", i5.scan_valid, 1);
            check("np2.scan_data", i5.scan_data,
                  (b == 5) ? 64'h123 : (b == 10) ? 64'h456 : 64'h0);
            check("np2.scan_last", i5.scan_last, (b == 14));
            @(negedge clk);
        end
        check("np2.scan_end", i5.scan_valid, 0);
        $display("[TB] 5x3 out-of-range and 15-beat scan");

        // Async reset at scan beat 20
        wr8(0, 0, 32'h77);
        i8.scan_start = 1'b1;
        @(negedge clk);
        i8.scan_start = 1'b0;
        repeat (20) @(negedge clk);
        check("arst.pre_valid", i8.scan_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("arst.valid", i8.scan_valid, 0);
        check("arst.busy", i8.busy, 0);
        check("arst.data", i8.scan_data, 0);
        check("arst.last", i8.scan_last, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int n = 0; n < 70; n++) begin
            if (i8.scan_last || i8.busy) seen++;
            @(negedge clk);
        end
        check("arst.no_last", seen, 0);
        $display("[TB] async reset mid-scan");
        scan8("scan_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
